// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the 12-bit/18-bit SECDED Hamming link.
//   DATA_W / CODE_W / SYN_W : data, codeword and syndrome widths
//   codeword_t, data_t      : codeword and data containers
//   syndrome_t              : 5-bit syndrome (position of a single error)
//   DATA_POS                : codeword position of each data bit d0..d11
//   ecc_status_t            : {corrected, detected, fatal} flag bundle
//   encode()                : data -> codeword (shared with encoders and benches)
package ecc_pkg;

  localparam int DATA_W = 12;
  localparam int CODE_W = 18;
  localparam int SYN_W  = 5;

  typedef logic [CODE_W-1:0] codeword_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SYN_W-1:0]  syndrome_t;

  // Non-power-of-two positions above 0, ascending; bit 0 is overall parity.
  localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17};

  typedef struct packed {
    logic corrected;
    logic detected;
    logic fatal;
  } ecc_status_t;

  function automatic codeword_t encode(data_t d);
    codeword_t cw;
    syndrome_t s;
    cw = '0;
    for (int i = 0; i < DATA_W; i++) cw[DATA_POS[i]] = d[i];
    s = '0;
    for (int p = 1; p < CODE_W; p++) if (cw[p]) s = s ^ SYN_W'(p);
    // Each parity bit sits at a power-of-two position, so setting bit k of
    // the data-only syndrome there cancels it to zero.
    for (int k = 0; k < SYN_W; k++) cw[1 << k] = s[k];
    cw[0] = ^cw[CODE_W-1:1];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_rx_if.sv
// hamming_rx_if: serial channel input plus decoded-word output of the receiver.
//   bit_in/bit_valid/sof : channel bits, MSB first, sof marks codeword bit 17
//   q/out_valid/out_ready: decoded data word with valid/ready handshake
//   err_*                : per-word status, valid with out_valid
//   overrun              : one-cycle pulse when a completed word is dropped
//   corr_cnt/fatal_cnt   : saturating statistics of accepted words
// modport slave is the receiver, modport master is the driving/sinking side.
interface hamming_rx_if;
  import ecc_pkg::*;

  logic        bit_in;
  logic        bit_valid;
  logic        sof;
  data_t       q;
  logic        out_valid;
  logic        out_ready;
  logic        err_corrected;
  logic        err_detected;
  logic        err_fatal;
  logic        overrun;
  logic [15:0] corr_cnt;
  logic [15:0] fatal_cnt;

  modport slave (
    input  bit_in, bit_valid, sof, out_ready,
    output q, out_valid, err_corrected, err_detected, err_fatal,
           overrun, corr_cnt, fatal_cnt
  );

  modport master (
    output bit_in, bit_valid, sof, out_ready,
    input  q, out_valid, err_corrected, err_detected, err_fatal,
           overrun, corr_cnt, fatal_cnt
  );
endinterface

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: combinational syndrome/parity for an 18-bit codeword.
//   code : codeword
//   s    : XOR of the positions (1..17) of all set bits
//   pf   : XOR of all 18 bits (1 = overall parity failure)
module hamming_syndrome
  import ecc_pkg::*;
(
  input  codeword_t code,
  output syndrome_t s,
  output logic      pf
);

  always_comb begin
    s = '0;
    for (int p = 1; p < CODE_W; p++) begin
      if (code[p]) s = s ^ SYN_W'(p);
    end
    pf = ^code;
  end

endmodule

// File: rtl/hamming_rx.sv
// hamming_rx: serial-input SECDED receiver.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high, clears all state
//   rx    : hamming_rx_if.slave (serial bits in, decoded words/flags/stats out)
// Pipeline: deserialiser -> stage 1 (codeword, syndrome, parity) -> output
// register (corrected data + flags). Both registers advance when the output
// register is empty or being accepted.
module hamming_rx
  import ecc_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  hamming_rx_if.slave   rx
);

  // Deserialiser: only 17 bits are buffered; the 18th comes straight from bit_in.
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [CODE_W-2:0] shreg_q, shreg_d;
  codeword_t         word_cw;
  logic              word_done;

  logic        s1_valid_q, s1_valid_d;
  codeword_t   s1_code_q, s1_code_d;
  syndrome_t   s1_syn_q, s1_syn_d;
  logic        s1_pf_q, s1_pf_d;

  logic        out_valid_q, out_valid_d;
  data_t       q_q, q_d;
  ecc_status_t status_q, status_d;
  logic        overrun_q, overrun_d;
  logic [15:0] corr_cnt_q, corr_cnt_d;
  logic [15:0] fatal_cnt_q, fatal_cnt_d;

  syndrome_t   word_syn;
  logic        word_pf;
  logic        advance;
  logic        handshake;
  codeword_t   fixed_cw;
  ecc_status_t dec_status;
  data_t       dec_data;

  assign word_cw = {shreg_q, rx.bit_in};

  hamming_syndrome u_syndrome (
    .code (word_cw),
    .s    (word_syn),
    .pf   (word_pf)
  );

  assign handshake = out_valid_q & rx.out_ready;
  assign advance   = ~out_valid_q | rx.out_ready;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    if (rx.bit_valid) begin
      if (rx.sof) begin
        // sof always restarts, silently discarding any partial word.
        shreg_d   = (CODE_W-1)'(rx.bit_in);
        bit_cnt_d = 5'd1;
      end else if (bit_cnt_q != 5'd0) begin
        shreg_d = word_cw[CODE_W-2:0];
        if (bit_cnt_q == 5'd17) begin
          word_done = 1'b1;
          bit_cnt_d = 5'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_pf_d    = s1_pf_q;
    overrun_d  = 1'b0;
    if (advance) s1_valid_d = 1'b0;
    if (word_done) begin
      if (!s1_valid_q || advance) begin
        s1_valid_d = 1'b1;
        s1_code_d  = word_cw;
        s1_syn_d   = word_syn;
        s1_pf_d    = word_pf;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Classification; fatal words pass through uncorrected.
  always_comb begin
    fixed_cw   = s1_code_q;
    dec_status = '0;
    if (s1_syn_q == '0) begin
      if (s1_pf_q) begin
        fixed_cw[0]          = ~s1_code_q[0];
        dec_status.corrected = 1'b1;
        dec_status.detected  = 1'b1;
      end
    end else if (!s1_pf_q || (s1_syn_q >= SYN_W'(CODE_W))) begin
      dec_status.fatal    = 1'b1;
      dec_status.detected = 1'b1;
    end else begin
      fixed_cw             = s1_code_q ^ (CODE_W'(1) << s1_syn_q);
      dec_status.corrected = 1'b1;
      dec_status.detected  = 1'b1;
    end
  end

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extract
    assign dec_data[gi] = fixed_cw[DATA_POS[gi]];
  end

  // Parity positions carry no data once the word is classified.
  logic unused_parity_bits;
  assign unused_parity_bits = ^{fixed_cw[0], fixed_cw[1], fixed_cw[2],
                                fixed_cw[4], fixed_cw[8], fixed_cw[16]};

  always_comb begin
    out_valid_d = out_valid_q;
    q_d         = q_q;
    status_d    = status_q;
    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        q_d      = dec_data;
        status_d = dec_status;
      end
    end
  end

  always_comb begin
    corr_cnt_d  = corr_cnt_q;
    fatal_cnt_d = fatal_cnt_q;
    if (handshake && status_q.corrected && (corr_cnt_q != 16'hFFFF))
      corr_cnt_d = corr_cnt_q + 16'd1;
    if (handshake && status_q.fatal && (fatal_cnt_q != 16'hFFFF))
      fatal_cnt_d = fatal_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_syn_q    <= '0;
      s1_pf_q     <= 1'b0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      status_q    <= '0;
      overrun_q   <= 1'b0;
      corr_cnt_q  <= '0;
      fatal_cnt_q <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s1_syn_q    <= s1_syn_d;
      s1_pf_q     <= s1_pf_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      status_q    <= status_d;
      overrun_q   <= overrun_d;
      corr_cnt_q  <= corr_cnt_d;
      fatal_cnt_q <= fatal_cnt_d;
    end
  end

  assign rx.q             = q_q;
  assign rx.out_valid     = out_valid_q;
  assign rx.err_corrected = status_q.corrected;
  assign rx.err_detected  = status_q.detected;
  assign rx.err_fatal     = status_q.fatal;
  assign rx.overrun       = overrun_q;
  assign rx.corr_cnt      = corr_cnt_q;
  assign rx.fatal_cnt     = fatal_cnt_q;

endmodule

// File: tb/tb_hamming_rx.sv
// tb_hamming_rx: directed vectors into hamming_rx; expected words go into a
// scoreboard queue and an independent monitor pops/compares on each handshake.
module tb_hamming_rx;
  import ecc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hamming_rx_if rx();

  hamming_rx dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx)
  );

  typedef struct packed {
    logic [7:0] id;
    data_t      q;
    logic [2:0] st;   // {corrected, detected, fatal}
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   failures   = 0;
  int   words_seen = 0;
  int   ov_pulses  = 0;

  // Monitor: one line per accepted word.
  always @(negedge clk) begin
    if (rx.overrun) ov_pulses++;
    if (!reset && rx.out_valid && rx.out_ready) begin
      exp_t e;
      checks++;
      words_seen++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word actual q=%h flags=%b required none",
                 rx.q, {rx.err_corrected, rx.err_detected, rx.err_fatal});
      end else begin
        e = sb.pop_front();
        if ({rx.q, rx.err_corrected, rx.err_detected, rx.err_fatal} !== {e.q, e.st}) begin
          failures++;
          $display("FAIL word_%0d actual q=%h flags=%b required q=%h flags=%b",
                   e.id, rx.q, {rx.err_corrected, rx.err_detected, rx.err_fatal}, e.q, e.st);
        end else begin
          $display("word_%0d q=%h flags=%b ok", e.id, rx.q,
                   {rx.err_corrected, rx.err_detected, rx.err_fatal});
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_word(input int id, input data_t q, input logic [2:0] st);
    exp_t e;
    e.id = 8'(id);
    e.q  = q;
    e.st = st;
    sb.push_back(e);
  endtask

  // Send codeword bits hi..lo (MSB first); sof accompanies bit 17.
  task automatic send_range(input codeword_t cw, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      rx.bit_in    = cw[i];
      rx.bit_valid = 1'b1;
      rx.sof       = (i == 17);
      @(posedge clk); #1;
    end
    rx.bit_valid = 1'b0;
    rx.sof       = 1'b0;
    rx.bit_in    = 1'b0;
  endtask

  task automatic send_cw(input codeword_t cw);
    send_range(cw, 17, 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, rx.out_valid, 0);
    chk({tag, "_q"}, rx.q, 0);
    chk({tag, "_flags"}, {rx.err_corrected, rx.err_detected, rx.err_fatal}, 0);
    chk({tag, "_overrun"}, rx.overrun, 0);
    chk({tag, "_corr_cnt"}, rx.corr_cnt, 0);
    chk({tag, "_fatal_cnt"}, rx.fatal_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov0;
    int w0;
    codeword_t cw;

    reset        = 1'b1;
    rx.bit_in    = 1'b0;
    rx.bit_valid = 1'b0;
    rx.sof       = 1'b0;
    rx.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Clean 0x00A, plus latency: nothing after edge N, valid after N+1.
    expect_word(1, 12'h00A, 3'b000);
    send_cw(18'h000A5);
    chk("lat_after_n", rx.out_valid, 0);
    @(posedge clk); #1;
    chk("lat_after_n1", rx.out_valid, 1);
    drain("drain_clean");
    chk("cnt_clean_corr", rx.corr_cnt, 0);
    chk("cnt_clean_fatal", rx.fatal_cnt, 0);

    // Bit 10 (d5) flipped: corrected.
    expect_word(2, 12'h00A, 3'b110);
    send_cw(18'h004A5);
    drain("drain_flip10");
    chk("cnt_flip10_corr", rx.corr_cnt, 1);

    // Bits 10 and 1 flipped: s=11, pf=0 -> fatal, raw data has d5 set.
    expect_word(3, 12'h02A, 3'b011);
    send_cw(18'h004A7);
    drain("drain_double");
    chk("cnt_double_fatal", rx.fatal_cnt, 1);

    // Bits 16, 2, 1 flipped: s=19, pf=1 -> out of range, raw data.
    expect_word(4, 12'h00A, 3'b011);
    send_cw(18'h100A3);
    drain("drain_s19");
    chk("cnt_s19_fatal", rx.fatal_cnt, 2);

    // Highest position (bit 17 = d11) flipped on 0xABC.
    expect_word(5, 12'hABC, 3'b110);
    cw = encode(12'hABC) ^ 18'h20000;
    send_cw(cw);
    drain("drain_flip17");
    chk("cnt_flip17_corr", rx.corr_cnt, 2);

    // Overall parity bit flipped: s=0, pf=1.
    expect_word(6, 12'h00A, 3'b110);
    send_cw(18'h000A4);
    drain("drain_flip0");
    chk("cnt_flip0_corr", rx.corr_cnt, 3);
    chk("no_overrun_ready_high", ov_pulses, 0);

    // Stall: three back-to-back words, only two fit.
    rx.out_ready = 1'b0;
    ov0 = ov_pulses;
    expect_word(7, 12'h123, 3'b000);
    expect_word(8, 12'h456, 3'b000);
    send_cw(encode(12'h123));
    send_cw(encode(12'h456));
    send_cw(encode(12'h789));
    repeat (3) @(posedge clk);
    #1;
    chk("overrun_pulses", ov_pulses - ov0, 1);
    chk("stall_held_q", rx.q, 12'h123);
    chk("stall_held_valid", rx.out_valid, 1);
    rx.out_ready = 1'b1;
    drain("drain_stall");
    repeat (5) @(posedge clk);
    chk("stall_no_third", sb.size(), 0);

    // Partial 9 bits then a fresh sof frame: exactly one word.
    w0 = words_seen;
    expect_word(9, 12'h00A, 3'b000);
    send_range(18'h000A5, 17, 9);
    send_cw(18'h000A5);
    drain("drain_restart");
    repeat (20) @(posedge clk);
    chk("restart_one_word", words_seen - w0, 1);

    // Reset with a held word, a word in stage 1 and a partial frame.
    rx.out_ready = 1'b0;
    send_cw(encode(12'h111));
    send_cw(encode(12'h222));
    cw = encode(12'h555);
    send_range(cw, 17, 9);
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    rx.out_ready = 1'b1;
    w0 = words_seen;
    send_range(cw, 8, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("midreset_no_word", words_seen - w0, 0);
    chk("midreset_valid_low", rx.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_rx.md
# hamming_rx

Serial-input SECDED receiver for the 12-bit/18-bit Hamming link. It deserialises incoming channel bits into 18-bit codewords and decodes them through a two-stage pipeline (syndrome, then correct). It presents 12-bit data with error flags on a valid/ready interface and keeps saturating error statistics. It sits at the channel-receive end, after bit recovery and before the sink/framing logic, and is the counterpart of the encoder/serialiser path.

## Interface
- No parameters. Widths come from `ecc_pkg`: DATA_W = 12, CODE_W = 18.
- `clk` input, 1: single system clock, rising edge.
- `reset` input, 1: asynchronous, active-high; clears all state.
- `bit_in` input, 1: channel bit; MSB (codeword bit 17) first.
- `bit_valid` input, 1: `bit_in` is sampled on this cycle.
- `sof` input, 1: start of frame, qualified by `bit_valid`; marks the bit-17 sample.
- `q` output, 12: decoded data.
- `out_valid` output, 1: `q` and the flags hold a word.
- `out_ready` input, 1: the sink accepts the word.
- `err_corrected` output, 1: a single error was corrected. Valid with `out_valid`.
- `err_detected` output, 1: the syndrome is nonzero or the overall parity fails.
- `err_fatal` output, 1: uncorrectable error.
- `overrun` output, 1: one-cycle pulse when a completed codeword is dropped.
- `corr_cnt` output, 16: saturating count of accepted corrected words.
- `fatal_cnt` output, 16: saturating count of accepted fatal words.

## Operation
- Codeword layout:
  - Bit 0 is overall even parity over bits 0..17.
  - Bits 1, 2, 4, 8 and 16 are Hamming parity bits.
  - Data d0..d11 occupy positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, in ascending order.
- Deserialiser:
  - A 5-bit bit counter runs 0..17.
  - A sample with `sof` loads bit 17 and sets the counter to 1.
  - Other valid samples shift in while the counter is at least 1.
  - Samples with the counter at 0 and no `sof` are discarded.
  - The 18th bit completes the word. The counter returns to 0 and the shift register goes to stage 1.
  - `sof` arriving mid-frame discards the partial word and restarts; no flag is raised.
- Stage 1 register:
  - Holds the codeword plus s (a 5-bit syndrome: the XOR of the positions of all set bits in 1..17) and pf (XOR of all 18 bits).
- Stage 2 / output register. Classification:
  - s = 0, pf = 0: clean. All flags are 0.
  - s = 0, pf = 1: bit 0 is in error. `err_corrected` = 1 and `err_detected` = 1.
  - s in 1..17, pf = 1: flip bit s. `err_corrected` = 1 and `err_detected` = 1.
  - s ≠ 0, pf = 0: double error. `err_fatal` = 1 and `err_detected` = 1.
  - s ≥ 18, pf = 1: out of range. `err_fatal` = 1 and `err_detected` = 1.
  - On fatal words, `q` carries the uncorrected data bits.
- Handshake and stalls:
  - The output register loads when it is empty or when `out_valid & out_ready` holds on that cycle.
  - Stage 1 advances under the same condition, otherwise it holds.
  - A word that completes while stage 1 is full and cannot advance is dropped, and `overrun` pulses. The held words are unaffected.
- Counters:
  - A counter increments on a handshake whose word carries the matching flag.
  - Both counters saturate at 0xFFFF.

## Timing
- Reset values are all 0: `q`, all flags, `out_valid`, `overrun`, both counters, and the bit counter.
- Reset mid-frame or mid-pipeline discards all words. No `out_valid` follows.
- Latency:
  - The 18th bit is sampled at edge N.
  - Stage 1 is loaded at edge N.
  - The output register is loaded at N+1, so `out_valid` is high after N+1, when the sink is ready.
- Flags and `q` stay stable while `out_valid & !out_ready`.
- Completing a word and a handshake in the same cycle both take effect; there is no bubble and no overrun.
- `overrun` is registered, asserting for the cycle after edge N.
- Throughput is one word per 18 valid bits. With `out_ready` tied high, no overrun can occur.

## Structure
- `ecc_pkg` holds:
  - DATA_W and CODE_W.
  - `codeword_t` (logic [17:0]) and `data_t` (logic [11:0]).
  - The data-position constant array.
  - The `ecc_status_t` struct {corrected, detected, fatal}.
  - The encode function, which the bench also uses.
- One combinational sub-module, `hamming_syndrome`: input codeword, outputs s and pf. It is reusable by other decoders.

## Test plan
- Data 0x00A has codeword 0x000A5. Send it clean, `out_ready` = 1:
  - `q` = 0x00A, flags 000.
  - `out_valid` is high after edge N+1.
- 0x000A5 with bit 10 flipped: `q` = 0x00A, `err_corrected` = 1, `err_detected` = 1, and `corr_cnt` becomes 1.
- 0x000A5 with bits 10 and 1 flipped (s = 11, pf = 0): `err_fatal` = 1, `err_detected` = 1, and `fatal_cnt` becomes 1.
- 0x000A5 with bits 16, 2 and 1 flipped (s = 19, pf = 1): `err_fatal` = 1, and `q` is the raw data.
- Hold `out_ready` = 0 and stream three clean words back to back:
  - Words 1 and 2 are held.
  - `overrun` pulses once, when word 3 completes.
  - Releasing `out_ready` yields only words 1 and 2, in order.
- Send 9 bits, then `sof` with a full 0x000A5 frame: exactly one word, `q` = 0x00A. Assert `reset` mid-frame: all outputs 0 and no `out_valid`.
